// File: rtl/bin_core_responder.sv
// Core-side bin storage and one-clause-per-cycle scanner that answers bin_manager with sat/unsat/backtrack.
// Optional BIN_CORE_STATS_EN adds core_runs_o, a saturating count of done pulses.
module bin_core_responder #(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int NUM_VARS_A_BIN    = 8,
  parameter int NUM_LVLS_A_BIN    = 8,
  parameter int WIDTH_BIN_ID      = 15,
  parameter int WIDTH_LVL         = 16,
  parameter int WIDTH_VAR_STATES  = 19,
  parameter int WIDTH_LVL_STATES  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_core_i,
  output logic                                       done_core_o,
  input  logic [WIDTH_BIN_ID-1:0]                    cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                       cur_lvl_i,
  output logic [WIDTH_LVL-1:0]                       cur_lvl_o,
  output logic                                       local_sat_o,
  output logic                                       local_unsat_o,
  output logic [WIDTH_BIN_ID-1:0]                    bkt_bin_o,
  output logic [WIDTH_LVL-1:0]                       bkt_lvl_o,
  input  logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_i,
  input  logic [NUM_CLAUSES_A_BIN-1:0]               rd_carray_i,
  input  logic [NUM_VARS_A_BIN*2-1:0]                clause_i,
  output logic [NUM_VARS_A_BIN*2-1:0]                clause_o,
  input  logic [NUM_VARS_A_BIN-1:0]                  wr_var_states_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_o,
  input  logic [NUM_LVLS_A_BIN-1:0]                  wr_lvl_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_o,
`ifdef BIN_CORE_STATS_EN
  output logic [15:0]                                core_runs_o,
`endif
  input  logic                                       base_lvl_en_i,
  input  logic [WIDTH_LVL-1:0]                       base_lvl_i
);

  localparam int CW = NUM_VARS_A_BIN * 2;
  localparam int IW = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1;
  localparam int LW = WIDTH_VAR_STATES - 3;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state;
  logic [NUM_CLAUSES_A_BIN-1:0][CW-1:0]             clauses;
  logic [NUM_VARS_A_BIN-1:0][WIDTH_VAR_STATES-1:0]  var_st;
  logic [NUM_LVLS_A_BIN-1:0][WIDTH_LVL_STATES-1:0]  lvl_st;
  logic [WIDTH_LVL-1:0]                             base_lvl;
  logic [WIDTH_BIN_ID-1:0]                          bin_q;
  logic [IW-1:0]                                    idx;
  logic                                             all_sat;

  logic [CW-1:0]        row;
  logic [1:0]           lit;
  logic [1:0]           val;
  logic [LW-1:0]        lv;
  logic                 row_true;
  logic                 row_open;
  logic                 row_present;
  logic                 row_sat;
  logic                 conflict;
  logic [WIDTH_LVL-1:0] max_lvl;
  logic [WIDTH_LVL-1:0] bkt_cand;

  always_comb begin
    clause_o = '0;
    for (int r = 0; r < NUM_CLAUSES_A_BIN; r++)
      if (rd_carray_i[r]) clause_o = clause_o | clauses[r];
  end

  assign vars_states_o = var_st;
  assign lvl_states_o  = lvl_st;

  // Storage is frozen while a scan is in flight so the scanned bin stays consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clauses  <= '0;
      var_st   <= '0;
      lvl_st   <= '0;
      base_lvl <= '0;
    end else if (state != SCAN) begin
      for (int r = 0; r < NUM_CLAUSES_A_BIN; r++)
        if (wr_carray_i[r]) clauses[r] <= clause_i;
      for (int v = 0; v < NUM_VARS_A_BIN; v++)
        if (wr_var_states_i[v]) var_st[v] <= vars_states_i[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
      for (int l = 0; l < NUM_LVLS_A_BIN; l++)
        if (wr_lvl_states_i[l]) lvl_st[l] <= lvl_states_i[l*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
      if (base_lvl_en_i) base_lvl <= base_lvl_i;
    end
  end

  always_comb begin
    row         = clauses[idx];
    lit         = '0;
    val         = '0;
    lv          = '0;
    row_true    = 1'b0;
    row_open    = 1'b0;
    row_present = 1'b0;
    max_lvl     = '0;
    for (int i = 0; i < NUM_VARS_A_BIN; i++) begin
      lit = row[2*i +: 2];
      val = var_st[i][1:0];
      lv  = var_st[i][WIDTH_VAR_STATES-1:3];
      if (lit != 2'b00) begin
        row_present = 1'b1;
        if (WIDTH_LVL'(lv) > max_lvl) max_lvl = WIDTH_LVL'(lv);
        if (val == 2'b00) row_open = 1'b1;
        else if ((lit == 2'b10 && val == 2'b10) || (lit == 2'b01 && val == 2'b01)) row_true = 1'b1;
      end
    end
    row_sat  = row_true || !row_present;
    conflict = !row_sat && !row_open;
    bkt_cand = (max_lvl == '0) ? '0 : max_lvl - 1'b1;
    if (base_lvl > bkt_cand) bkt_cand = base_lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done_core_o   <= 1'b0;
      cur_lvl_o     <= '0;
      local_sat_o   <= 1'b0;
      local_unsat_o <= 1'b0;
      bkt_bin_o     <= '0;
      bkt_lvl_o     <= '0;
      bin_q         <= '0;
      idx           <= '0;
      all_sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_core_o <= 1'b0;
          if (start_core_i) begin
            bin_q         <= cur_bin_num_i;
            cur_lvl_o     <= cur_lvl_i;
            idx           <= '0;
            all_sat       <= 1'b1;
            local_sat_o   <= 1'b0;
            local_unsat_o <= 1'b0;
            bkt_bin_o     <= '0;
            bkt_lvl_o     <= '0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (conflict) begin
            local_unsat_o <= 1'b1;
            bkt_bin_o     <= bin_q;
            bkt_lvl_o     <= bkt_cand;
            done_core_o   <= 1'b1;
            state         <= DONE;
          end else if (idx == IW'(NUM_CLAUSES_A_BIN - 1)) begin
            local_sat_o <= all_sat & row_sat;
            done_core_o <= 1'b1;
            state       <= DONE;
          end else begin
            all_sat <= all_sat & row_sat;
            idx     <= idx + 1'b1;
          end
        end
        DONE: begin
          done_core_o <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          done_core_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef BIN_CORE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_runs_o <= '0;
    else if (done_core_o && core_runs_o != 16'hFFFF) core_runs_o <= core_runs_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bin_core_responder.sv
// Self-checking bench for bin_core_responder: directed table, hand sequences, and randomized bins vs a reference model.
module tb_bin_core_responder;
  localparam int NC  = 8;
  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WB  = 15;
  localparam int WL  = 16;
  localparam int WVS = 19;
  localparam int WLS = 16;

  logic clk = 0;
  logic rst;
  logic start_core_i = 0;
  logic done_core_o;
  logic [WB-1:0] cur_bin_num_i = '0;
  logic [WL-1:0] cur_lvl_i = '0;
  logic [WL-1:0] cur_lvl_o;
  logic local_sat_o, local_unsat_o;
  logic [WB-1:0] bkt_bin_o;
  logic [WL-1:0] bkt_lvl_o;
  logic [NC-1:0] wr_carray_i = '0, rd_carray_i = '0;
  logic [NV*2-1:0] clause_i = '0, clause_o;
  logic [NV-1:0] wr_var_states_i = '0;
  logic [WVS*NV-1:0] vars_states_i = '0, vars_states_o;
  logic [NL-1:0] wr_lvl_states_i = '0;
  logic [WLS*NL-1:0] lvl_states_i = '0, lvl_states_o;
  logic base_lvl_en_i = 0;
  logic [WL-1:0] base_lvl_i = '0;
`ifdef BIN_CORE_STATS_EN
  logic [15:0] core_runs_o;
  int runs_exp = 0;
`endif

  bin_core_responder dut (
    .clk(clk), .rst(rst), .start_core_i(start_core_i), .done_core_o(done_core_o),
    .cur_bin_num_i(cur_bin_num_i), .cur_lvl_i(cur_lvl_i), .cur_lvl_o(cur_lvl_o),
    .local_sat_o(local_sat_o), .local_unsat_o(local_unsat_o),
    .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o),
    .wr_carray_i(wr_carray_i), .rd_carray_i(rd_carray_i),
    .clause_i(clause_i), .clause_o(clause_o),
    .wr_var_states_i(wr_var_states_i), .vars_states_i(vars_states_i), .vars_states_o(vars_states_o),
    .wr_lvl_states_i(wr_lvl_states_i), .lvl_states_i(lvl_states_i), .lvl_states_o(lvl_states_o),
`ifdef BIN_CORE_STATS_EN
    .core_runs_o(core_runs_o),
`endif
    .base_lvl_en_i(base_lvl_en_i), .base_lvl_i(base_lvl_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of what the bin should hold, updated only by the bench's own writes.
  logic [NV*2-1:0] m_clause [NC];
  logic [WVS-1:0]  m_var [NV];
  int              m_base;

  typedef struct {
    int          row;
    logic [15:0] clause;
    logic [18:0] var0;
    int          base;
    bit          sat;
    bit          unsat;
    int          bkt;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NC; r++) m_clause[r] = '0;
    for (int v = 0; v < NV; v++) m_var[v] = '0;
    m_base = 0;
  endtask

  task automatic write_clause(input int r, input logic [NV*2-1:0] d);
    wr_carray_i = '0;
    wr_carray_i[r] = 1'b1;
    clause_i = d;
    tick();
    wr_carray_i = '0;
    m_clause[r] = d;
  endtask

  task automatic clear_all_rows();
    wr_carray_i = '1;
    clause_i = '0;
    tick();
    wr_carray_i = '0;
    for (int r = 0; r < NC; r++) m_clause[r] = '0;
  endtask

  task automatic write_vars_from_model();
    for (int v = 0; v < NV; v++) vars_states_i[v*WVS +: WVS] = m_var[v];
    wr_var_states_i = '1;
    tick();
    wr_var_states_i = '0;
  endtask

  task automatic write_base(input int b);
    base_lvl_i = WL'(b);
    base_lvl_en_i = 1'b1;
    tick();
    base_lvl_en_i = 1'b0;
    m_base = b;
  endtask

  // Reference: walk rows in order, first row with no true literal and no open literal is the conflict.
  task automatic model_eval(output bit sat, output bit unsat, output int bkt, output int lat);
    int n_sat;
    sat = 0; unsat = 0; bkt = 0; lat = NC + 1; n_sat = 0;
    for (int r = 0; r < NC; r++) begin
      int n_lits, n_true, n_open, top;
      n_lits = 0; n_true = 0; n_open = 0; top = 0;
      for (int v = 0; v < NV; v++) begin
        int code, value, lvl;
        code  = int'(m_clause[r][2*v +: 2]);
        value = int'(m_var[v][1:0]);
        lvl   = int'(m_var[v][18:3]);
        if (code != 0) begin
          n_lits++;
          if (lvl > top) top = lvl;
          if (value == 0) n_open++;
          else if (code == value) n_true++;
        end
      end
      if (n_lits == 0 || n_true > 0) n_sat++;
      else if (n_open == 0) begin
        unsat = 1;
        bkt = (top > 0) ? top - 1 : 0;
        if (m_base > bkt) bkt = m_base;
        lat = r + 2;
        return;
      end
    end
    sat = (n_sat == NC);
  endtask

  // Latency is the edge number (start sampled at edge 0) on which the manager samples done high.
  task automatic run(input string name, input bit e_sat, input bit e_unsat, input int e_bkt,
                     input int e_lat);
    logic [WB-1:0] bin;
    logic [WL-1:0] lvl;
    int lat, ndone;
    bin = WB'($urandom);
    lvl = WL'($urandom);
    cur_bin_num_i = bin;
    cur_lvl_i = lvl;
    start_core_i = 1'b1;
    tick();
    start_core_i = 1'b0;
    lat = -1; ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) tick();
      if (done_core_o) begin
        ndone++;
        if (lat < 0) lat = c + 1;
      end
    end
    check({name, " latency"}, lat, e_lat);
    check({name, " done_pulses"}, ndone, 1);
    check({name, " sat"}, local_sat_o, e_sat);
    check({name, " unsat"}, local_unsat_o, e_unsat);
    check({name, " bkt_lvl"}, bkt_lvl_o, e_unsat ? WL'(e_bkt) : '0);
    check({name, " bkt_bin"}, bkt_bin_o, e_unsat ? bin : '0);
    check({name, " cur_lvl"}, cur_lvl_o, lvl);
`ifdef BIN_CORE_STATS_EN
    runs_exp++;
`endif
  endtask

  function automatic logic [1:0] rand_lit();
    int r;
    r = $urandom_range(0, 9);
    return (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : 2'b01;
  endfunction

  vec_t vecs [7];

  initial begin
    bit es, eu;
    int eb, el;
    logic [NV*2-1:0] tmp;

    vecs[0] = '{0, 16'h0006, 19'h00002, 0, 1, 0, 0, 9};
    vecs[1] = '{0, 16'h0002, {16'd3, 3'b001}, 0, 0, 1, 2, 2};
    vecs[2] = '{0, 16'h0002, {16'd3, 3'b001}, 5, 0, 1, 5, 2};
    vecs[3] = '{0, 16'h0002, 19'h00000, 0, 0, 0, 0, 9};
    vecs[4] = '{0, 16'h0001, {16'd0, 3'b001}, 0, 1, 0, 0, 9};
    vecs[5] = '{0, 16'h0002, {16'd0, 3'b001}, 0, 0, 1, 0, 2};
    vecs[6] = '{7, 16'h0002, {16'd3, 3'b001}, 0, 0, 1, 2, 9};

    // Reset state
    rst = 1'b1;
    model_clear();
    #1;
    for (int r = 0; r < NC; r++) begin
      rd_carray_i = NC'(1) << r;
      #1 check("reset clause_o", clause_o, '0);
    end
    rd_carray_i = '1;
    #1 check("reset clause_o all", clause_o, '0);
    check("reset done", done_core_o, 0);
    check("reset sat/unsat", {local_sat_o, local_unsat_o}, 0);
    check("reset bkt", {bkt_bin_o, bkt_lvl_o, cur_lvl_o}, 0);
    check("reset vars", vars_states_o, 0);
    check("reset lvls", lvl_states_o, 0);
    rd_carray_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      clear_all_rows();
      for (int v = 0; v < NV; v++) m_var[v] = '0;
      m_var[0] = vecs[i].var0;
      write_vars_from_model();
      write_base(vecs[i].base);
      write_clause(vecs[i].row, vecs[i].clause);
      run($sformatf("vec%0d", i), vecs[i].sat, vecs[i].unsat, vecs[i].bkt, vecs[i].lat);
    end

    // Same-cycle write and read of row 3 returns old data, then new data.
    write_clause(3, 16'hA5A5);
    rd_carray_i = 8'h08;
    wr_carray_i = 8'h08;
    clause_i = 16'h5A5A;
    #1 check("wr+rd same cycle old", clause_o, 16'hA5A5);
    tick();
    wr_carray_i = '0;
    m_clause[3] = 16'h5A5A;
    check("wr+rd next cycle new", clause_o, 16'h5A5A);

    // Multi-hot write and OR'ed multi-hot read
    wr_carray_i = 8'h06;
    clause_i = 16'h00F0;
    tick();
    wr_carray_i = '0;
    write_clause(2, 16'h0F00);
    rd_carray_i = 8'h06;
    #1 check("multi-hot read OR", clause_o, 16'h0FF0);
    rd_carray_i = '0;
    #1 check("rd none", clause_o, 0);

    // Level state write/readback
    for (int l = 0; l < NL; l++) lvl_states_i[l*WLS +: WLS] = WLS'(16'h1000 + l * 3);
    wr_lvl_states_i = 8'hA5;
    tick();
    wr_lvl_states_i = '0;
    for (int l = 0; l < NL; l++) begin
      tmp = (l == 0 || l == 2 || l == 5 || l == 7) ? WLS'(16'h1000 + l * 3) : '0;
      check($sformatf("lvl_state%0d", l), lvl_states_o[l*WLS +: WLS], tmp);
    end

    // Writes and a second start during SCAN are ignored.
    clear_all_rows();
    for (int v = 0; v < NV; v++) m_var[v] = '0;
    m_var[0] = 19'h00002;
    write_vars_from_model();
    write_base(0);
    write_clause(0, 16'h0006);
    begin
      int lat, ndone;
      start_core_i = 1'b1;
      tick();
      start_core_i = 1'b0;
      lat = -1; ndone = 0;
      for (int c = 0; c < 30; c++) begin
        if (c > 0) tick();
        if (c == 2) begin
          wr_carray_i = 8'h20; clause_i = 16'h0001;
          wr_var_states_i = '1; vars_states_i = '0;
          base_lvl_en_i = 1'b1; base_lvl_i = 16'd9;
          start_core_i = 1'b1;
        end else if (c == 3) begin
          wr_carray_i = '0; wr_var_states_i = '0; base_lvl_en_i = 1'b0; start_core_i = 1'b0;
        end
        if (done_core_o) begin
          ndone++;
          if (lat < 0) lat = c + 1;
        end
      end
      check("scan-lock latency", lat, 9);
      check("scan-lock done_pulses", ndone, 1);
      check("scan-lock sat", {local_sat_o, local_unsat_o}, 2'b10);
      rd_carray_i = 8'h20;
      #1 check("scan-lock row5 unchanged", clause_o, 0);
      rd_carray_i = '0;
      check("scan-lock var0 unchanged", vars_states_o[WVS-1:0], 19'h00002);
`ifdef BIN_CORE_STATS_EN
      runs_exp++;
`endif
    end

    // Randomized bins against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NC; r++) begin
        for (int v = 0; v < NV; v++) tmp[2*v +: 2] = rand_lit();
        write_clause(r, tmp);
      end
      for (int v = 0; v < NV; v++) begin
        int k;
        k = $urandom_range(0, 19);
        m_var[v] = {16'($urandom_range(0, 20)), 1'b0, (k < 2) ? 2'b00 : (k < 11) ? 2'b10 : 2'b01};
      end
      write_vars_from_model();
      write_base($urandom_range(0, 10));
      model_eval(es, eu, eb, el);
      run($sformatf("rand%0d", t), es, eu, eb, el);
    end

`ifdef BIN_CORE_STATS_EN
    tick();
    check("core_runs", core_runs_o, 16'(runs_exp));
`endif

    // Reset mid-SCAN aborts without a done pulse and clears storage.
    start_core_i = 1'b1;
    tick();
    start_core_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    model_clear();
    check("midscan rst done", done_core_o, 0);
    check("midscan rst vars", vars_states_o, 0);
`ifdef BIN_CORE_STATS_EN
    check("midscan rst core_runs", core_runs_o, 0);
`endif
    tick();
    rst = 1'b0;
    begin
      int ndone;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (done_core_o) ndone++;
      end
      check("midscan rst no done", ndone, 0);
      check("midscan rst results", {local_sat_o, local_unsat_o, bkt_lvl_o}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
